// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain half of an asynchronous FIFO.
// Keeps the binary/Gray write pointers and brings the read-domain Gray pointer
// across two flops. It also produces registered full, occupancy and optional
// almost-full status.
// Optional feature macro: WPTR_ALMOST_FULL_EN adds the walmost_full port.
// All status is pessimistic: a read only frees space once its pointer has
// crossed the synchronizer, so an accepted write can never overflow the RAM.
module fifo_wptr_full #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic [ADDR_WIDTH:0]   wcount
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic                  walmost_full
`endif
);

  // Reject configurations the pointer arithmetic cannot support.
  if (ADDR_WIDTH < 2 || DATA_WIDTH < 1 || AFULL_THRESH < 0 ||
      AFULL_THRESH > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("fifo_wptr_full: illegal parameter combination");
  end

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointer and status registers.
  logic [ADDR_WIDTH:0] r_wbin;
  logic [ADDR_WIDTH:0] r_wgray;
  logic [ADDR_WIDTH:0] r_rq1;
  logic [ADDR_WIDTH:0] r_rq2;
  logic                r_wfull;
  logic [ADDR_WIDTH:0] r_wcount;

  // Next-state values.
  logic                w_wr_accept;
  logic [ADDR_WIDTH:0] w_wbin_next;
  logic [ADDR_WIDTH:0] w_wgray_next;
  logic [ADDR_WIDTH:0] w_rq2_bin;
  logic [ADDR_WIDTH:0] w_full_pattern;
  logic                w_wfull_next;
  logic [ADDR_WIDTH:0] w_wcount_next;

  // Two-flop synchronizer for the read-domain Gray pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= rptr_gray;
      r_rq2 <= r_rq1;
    end
  end

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of bits MSB..i.
  always_comb begin
    w_rq2_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      w_rq2_bin[i] = ^(r_rq2 >> i);
    end
  end

  // Write acceptance and next pointer values; writes while full are dropped silently.
  always_comb begin
    w_wr_accept  = winc & ~r_wfull;
    w_wbin_next  = w_wr_accept ? (r_wbin + PTR_ONE) : r_wbin;
    w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  end

  // Full when the write pointer has lapped the read pointer by one full depth:
  // in Gray form that is the read pointer with its two MSBs inverted.
  always_comb begin
    w_full_pattern = {~r_rq2[ADDR_WIDTH:ADDR_WIDTH-1], r_rq2[ADDR_WIDTH-2:0]};
    w_wfull_next   = (w_wgray_next == w_full_pattern);
    w_wcount_next  = w_wbin_next - w_rq2_bin;
  end

  // Pointer registers: binary for addressing, Gray for the domain crossing.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
    end
  end

  // Registered status so that no output has a combinational path from an input.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wfull  <= 1'b0;
      r_wcount <= '0;
    end else begin
      r_wfull  <= w_wfull_next;
      r_wcount <= w_wcount_next;
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  logic r_walmost_full;
  logic w_walmost_full_next;

  // Almost-full compares the same next occupancy that feeds wcount.
  always_comb begin
    w_walmost_full_next = (w_wcount_next >= AF_THRESH);
  end

  // Almost-full register, updated alongside wfull.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_walmost_full <= 1'b0;
    end else begin
      r_walmost_full <= w_walmost_full_next;
    end
  end

  assign walmost_full = r_walmost_full;
`endif

  assign waddr     = r_wbin[ADDR_WIDTH-1:0];
  assign wptr_gray = r_wgray;
  assign wfull     = r_wfull;
  assign wcount    = r_wcount;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: bench for fifo_wptr_full with ADDR_WIDTH=3 (depth 8), AFULL_THRESH=4.
// Almost-full checks are included when WPTR_ALMOST_FULL_EN is defined.
module tb_fifo_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [3:0] rptr_gray;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic [3:0] wcount;
  logic       walmost_full;

  int total = 0;
  int bad   = 0;

  // Expected entry: {waddr[12:10], gray[9:6], full[5], count[4:1], almost_full[0]}
  logic [12:0] exp_q[$];
  logic [12:0] sb_e;

  // Model state
  logic [3:0] m_wbin;
  logic [3:0] m_rq1;
  logic [3:0] m_rq2;
  logic [3:0] m_rb;
  logic       m_full;

  fifo_wptr_full #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (3),
    .AFULL_THRESH(4)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .rptr_gray   (rptr_gray),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .wfull       (wfull),
    .wcount      (wcount)
`ifdef WPTR_ALMOST_FULL_EN
    ,
    .walmost_full(walmost_full)
`endif
  );

`ifndef WPTR_ALMOST_FULL_EN
  assign walmost_full = 1'b0;
`endif

  // Clock
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Scoreboard: pop one expectation per edge, after outputs settle.
  always @(posedge wclk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      total++;
      if (waddr !== sb_e[12:10]) begin
        bad++;
        $display("FAIL sb_waddr t=%0t got=%0d exp=%0d", $time, waddr, sb_e[12:10]);
      end
      total++;
      if (wptr_gray !== sb_e[9:6]) begin
        bad++;
        $display("FAIL sb_gray t=%0t got=%h exp=%h", $time, wptr_gray, sb_e[9:6]);
      end
      total++;
      if (wfull !== sb_e[5]) begin
        bad++;
        $display("FAIL sb_full t=%0t got=%b exp=%b", $time, wfull, sb_e[5]);
      end
      total++;
      if (wcount !== sb_e[4:1]) begin
        bad++;
        $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, wcount, sb_e[4:1]);
      end
`ifdef WPTR_ALMOST_FULL_EN
      total++;
      if (walmost_full !== sb_e[0]) begin
        bad++;
        $display("FAIL sb_afull t=%0t got=%b exp=%b", $time, walmost_full, sb_e[0]);
      end
`endif
    end
  end

  // Drive one cycle at the falling edge, predict the edge result, wait past the edge.
  task automatic step(input logic inc, input logic [3:0] rb);
    logic [3:0] cnt;
    @(negedge wclk);
    winc      = inc;
    rptr_gray = rb ^ (rb >> 1);
    m_rb      = rb;
    if (inc && !m_full) m_wbin = m_wbin + 4'd1;
    cnt    = m_wbin - m_rq2;
    m_full = (cnt == 4'd8);
    exp_q.push_back({m_wbin[2:0], m_wbin ^ (m_wbin >> 1), m_full, cnt, (cnt >= 4'd4)});
    m_rq2 = m_rq1;
    m_rq1 = rb;
    @(posedge wclk);
    #2;
  endtask

  task automatic model_reset();
    m_wbin = 4'd0;
    m_rq1  = 4'd0;
    m_rq2  = 4'd0;
    m_rb   = 4'd0;
    m_full = 1'b0;
  endtask

  task automatic test_reset();
    // a few writes, then asynchronous reset between edges
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    wrst_n = 1'b0;
    #1;
    total++;
    if ({waddr, wptr_gray, wfull, wcount, walmost_full} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset got waddr=%0d gray=%h full=%b cnt=%0d af=%b exp all 0",
               waddr, wptr_gray, wfull, wcount, walmost_full);
    end
    winc      = 1'b0;
    rptr_gray = 4'd0;
    model_reset();
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0);
      total++;
      if ({waddr, wptr_gray, wfull, wcount, walmost_full} !== 13'd0) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d got waddr=%0d gray=%h full=%b cnt=%0d exp all 0",
                 i, waddr, wptr_gray, wfull, wcount);
      end
    end
  endtask

  task automatic test_fill();
    logic [3:0] g_tab [8];
    g_tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 4'd0);
      total++;
      if (waddr !== 3'(n % 8)) begin
        bad++;
        $display("FAIL fill_waddr n=%0d got=%0d exp=%0d", n, waddr, n % 8);
      end
      total++;
      if (wptr_gray !== g_tab[n-1]) begin
        bad++;
        $display("FAIL fill_gray n=%0d got=%h exp=%h", n, wptr_gray, g_tab[n-1]);
      end
      total++;
      if (wcount !== 4'(n) || wfull !== (n == 8)) begin
        bad++;
        $display("FAIL fill_status n=%0d got cnt=%0d full=%b exp cnt=%0d full=%b",
                 n, wcount, wfull, n, (n == 8));
      end
`ifdef WPTR_ALMOST_FULL_EN
      total++;
      if (walmost_full !== (n >= 4)) begin
        bad++;
        $display("FAIL fill_afull n=%0d got=%b exp=%b", n, walmost_full, (n >= 4));
      end
`endif
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd0);
      total++;
      if (waddr !== 3'd0 || wptr_gray !== 4'hC || wcount !== 4'd8 || wfull !== 1'b1) begin
        bad++;
        $display("FAIL overflow i=%0d got waddr=%0d gray=%h cnt=%0d full=%b exp 0/c/8/1",
                 i, waddr, wptr_gray, wcount, wfull);
      end
    end
  endtask

  task automatic test_drain_release();
    for (int e = 1; e <= 3; e++) begin
      step(1'b0, 4'd1);
      total++;
      if (wfull !== (e < 3) || wcount !== ((e < 3) ? 4'd8 : 4'd7)) begin
        bad++;
        $display("FAIL drain_release edge=%0d got full=%b cnt=%0d exp full=%b cnt=%0d",
                 e, wfull, wcount, (e < 3), (e < 3) ? 8 : 7);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev_g;
    logic [3:0] old_b;
    logic [3:0] rb;
    for (int pass = 0; pass < 3; pass++) begin
      for (int k = 0; k < 10; k++) begin
        prev_g = wptr_gray;
        old_b  = m_wbin;
        step(1'b1, m_rb);
        total++;
        if ($countones(prev_g ^ wptr_gray) != ((old_b != m_wbin) ? 1 : 0)) begin
          bad++;
          $display("FAIL wrap_hamming pass=%0d got prev=%h cur=%h exp dist=%0d",
                   pass, prev_g, wptr_gray, (old_b != m_wbin) ? 1 : 0);
        end
        if (old_b == 4'hF && m_wbin == 4'h0) begin
          total++;
          if (wptr_gray !== 4'h0 || waddr !== 3'd0) begin
            bad++;
            $display("FAIL wrap_rollover got gray=%h waddr=%0d exp gray=0 waddr=0",
                     wptr_gray, waddr);
          end
        end
      end
      for (int k = 0; k < 11; k++) begin
        rb     = (m_rb != m_wbin) ? m_rb + 4'd1 : m_rb;
        prev_g = wptr_gray;
        step(1'b0, rb);
        total++;
        if (wptr_gray !== prev_g) begin
          bad++;
          $display("FAIL wrap_idle_gray got=%h exp=%h", wptr_gray, prev_g);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rb;
    for (int k = 0; k < 16; k++) begin
      rb = (m_rb != m_wbin && $urandom_range(0, 3) != 0) ? m_rb + 4'd1 : m_rb;
      step(1'($urandom_range(0, 4) != 0), rb);
    end
    for (int k = 0; k < 3; k++) step(1'b0, m_rb);
  endtask

  initial begin
    wrst_n    = 1'b0;
    winc      = 1'b0;
    rptr_gray = 4'd0;
    model_reset();
    #1;
    total++;
    if ({waddr, wptr_gray, wfull, wcount, walmost_full} !== 13'd0) begin
      bad++;
      $display("FAIL power_on_reset got waddr=%0d gray=%h full=%b cnt=%0d exp all 0",
               waddr, wptr_gray, wfull, wcount);
    end
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
    test_back_to_back();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and full-flag generator for the asynchronous FIFO. It lives in the write clock domain and does four things:
- advances the binary write address and its Gray-coded copy;
- double-flop synchronizes the read-domain Gray pointer;
- converts that pointer to binary for occupancy arithmetic;
- produces registered full, fill-count and optional almost-full status.

Its Gray output feeds the read-domain synchronizer, and its internal Gray-to-binary conversion consumes the synchronized read pointer.

## Interface
- DATA_WIDTH, 8, data width of the FIFO. Carried for parameter uniformity; unused inside this block.
- ADDR_WIDTH, 6, address bits. Depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits wide. ADDR_WIDTH must be at least 2.
- AFULL_THRESH, 2^ADDR_WIDTH-4, occupancy at or above which almost-full asserts.
- wclk  input  1  write-domain clock. All state updates on its rising edge.
- wrst_n  input  1  asynchronous, active-low reset. Asserts immediately; its release is synchronous to wclk upstream.
- winc  input  1  write request for this cycle.
- rptr_gray  input  ADDR_WIDTH+1  Gray read pointer from the read domain. Asynchronous to wclk.
- waddr  output  ADDR_WIDTH  RAM write address (low bits of the binary pointer).
- wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wfull  output  1  registered full flag.
- wcount  output  ADDR_WIDTH+1  registered occupancy as seen from the write domain. Range 0..2^ADDR_WIDTH.
- walmost_full  output  1  registered almost-full flag. Present only when the macro is defined.

## Operation
- Sync stage: rptr_gray passes through two flops, rq1 then rq2.
- rq2 is converted to binary, giving rq2_bin: bit i is the XOR of rq2 bits ADDR_WIDTH down to i.
- Write acceptance: a write is accepted when winc=1 and wfull=0. On acceptance wbin_next = wbin+1; otherwise wbin_next = wbin.
- winc while wfull=1 is ignored: no pointer change and no error flag.
- Gray encoding: wgray_next = wbin_next ^ (wbin_next >> 1). wbin and wptr_gray register the next values.
- Pointer wrap: all pointer arithmetic is modulo 2^(ADDR_WIDTH+1). wbin rolls from all-ones to 0, and the extra MSB toggles each pass through the FIFO.
- Full: wfull_next = 1 when wgray_next equals rq2 with its two MSBs inverted and its remaining bits unchanged.
- Count: wcount_next = (wbin_next − rq2_bin) mod 2^(ADDR_WIDTH+1).
- Simultaneous events: when a write and a read-pointer advance arrive in the same cycle, both take effect. The count reflects the net change.
- Pessimism: full is pessimistic. After a read, wfull and wcount release only once the new read pointer has crossed the two sync flops. Overflow is impossible.
- Reset (asynchronous, any time, including mid-burst) clears:
  - wbin, wptr_gray, rq1 and rq2 to 0;
  - wfull and wcount to 0;
  - walmost_full to 0.
- Control flow is pointer/flag registers only; there is no state machine beyond them.

## Timing
- waddr and wptr_gray change one wclk edge after an accepted winc.
- wfull is valid on the same edge as the write that fills the FIFO. The next winc is blocked with zero cycles of slip.
- A read-side pointer change appears in rq2 after 2 wclk edges. wfull, wcount and walmost_full update on the 3rd edge.
- Only one bit of wptr_gray changes per edge. This is required for safe crossing.
- All outputs come directly from flops; there are no combinational paths from input to output.

## Configuration
- WPTR_ALMOST_FULL_EN defined:
  - the walmost_full port exists;
  - walmost_full_next = (wcount_next >= AFULL_THRESH);
  - walmost_full is registered alongside wfull.
- WPTR_ALMOST_FULL_EN undefined: the port, its register and the comparator are absent. All other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=3 (depth 8), AFULL_THRESH=4, and the macro defined unless stated.

1. Reset checks:
   - Assert wrst_n=0 mid-operation → all outputs 0 immediately, with no clock edge needed.
   - Release reset, winc=0 for 5 cycles → outputs stay 0.
2. Fill with rptr_gray=0 held: 8 consecutive winc → waddr steps through 0..7, wptr_gray steps 0,1,3,2,6,7,5,4 → then 0xC after the 8th write. wfull=1 and wcount=8 on the 8th edge. walmost_full=1 from the 4th edge.
3. Overflow attempt: with the FIFO full, 3 more winc → wbin, wptr_gray and wcount unchanged, wfull stays 1.
4. Drain release: with the FIFO full, drive rptr_gray=1 (one read) → wfull drops and wcount becomes 7 exactly 3 edges later, not earlier.
5. Wrap: repeat fill/drain 3 times, with rptr_gray tracking the writes → wbin wraps 15→0 and the MSB toggles. wfull asserts only at a true 8-entry difference. wptr_gray changes by Hamming distance 1 on every step.
6. Macro off (macro undefined): rebuild and rerun scenario 2 → same waddr/wfull/wcount sequence, and the walmost_full port is absent.
